uart_frame_assembler: RTL and testbench

Sits between the UART byte receiver and the AES core's input registers. Parses a byte stream into framed commands: a header byte selects plaintext/ciphertext block (16 bytes) or key (32 bytes). Assembles payload MSB-first and presents the completed 128-bit text or 256-bit key with a one-cycle valid strobe. An inter-byte timeout discards stalled frames.

---
 rtl/aes_uart_pkg.sv | 23 ++
 rtl/uart_frame_assembler.sv | 150 +++++++++++++++
 tb/tb_uart_frame_assembler.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/aes_uart_pkg.sv
// Shared definitions for the UART-to-AES frame assembler.
//   state_e      : frame parser states
//   TEXT_BYTES   : payload length of a text (plaintext/ciphertext) block
//   KEY_BYTES    : payload length of a key
//   TEXT_W/KEY_W : widths of the assembled text block and key
//   HDR_*_DEF    : default header bytes ('M' for text, 'K' for key)
package aes_uart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RX_TEXT = 2'd1,
        RX_KEY  = 2'd2
    } state_e;

    localparam int unsigned TEXT_BYTES = 16;
    localparam int unsigned KEY_BYTES  = 32;
    localparam int unsigned TEXT_W     = 128;
    localparam int unsigned KEY_W      = 256;

    localparam logic [7:0] HDR_TEXT_DEF = 8'h4D;
    localparam logic [7:0] HDR_KEY_DEF  = 8'h4B;

endpackage

// File: rtl/uart_frame_assembler.sv
// Parses a UART byte stream into framed AES commands.
// A header byte selects a 16-byte text block or a 32-byte key; the payload
// is assembled MSB-first and published with a one-cycle valid strobe.
// A frame stalled longer than TIMEOUT_CYCLES idle clocks is discarded.
//
// Ports:
//   clk_i          in   1    system clock
//   rst_ni         in   1    asynchronous active-low reset
//   rx_data_i      in   8    received byte
//   rx_valid_i     in   1    one-cycle strobe qualifying rx_data_i
//   metin_o        out  128  last completed text block
//   metin_valid_o  out  1    one-cycle pulse when metin_o updates
//   key_o          out  256  last completed key
//   key_valid_o    out  1    one-cycle pulse when key_o updates
//   busy_o         out  1    high while a frame is in progress
//   frame_err_o    out  1    one-cycle pulse on unknown header or timeout
module uart_frame_assembler
    import aes_uart_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  HDR_TEXT       = HDR_TEXT_DEF,
    parameter logic [7:0]  HDR_KEY        = HDR_KEY_DEF
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [7:0]          rx_data_i,
    input  logic                rx_valid_i,
    output logic [TEXT_W-1:0]   metin_o,
    output logic                metin_valid_o,
    output logic [KEY_W-1:0]    key_o,
    output logic                key_valid_o,
    output logic                busy_o,
    output logic                frame_err_o
);

    localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [5:0] TEXT_LAST = 6'(TEXT_BYTES - 1);
    localparam logic [5:0] KEY_LAST  = 6'(KEY_BYTES - 1);

    state_e              state_q, state_d;
    logic [5:0]          bcnt_q, bcnt_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic [KEY_W-1:0]    shreg_q, shreg_d;
    logic [KEY_W-1:0]    shifted;
    logic [TEXT_W-1:0]   metin_d;
    logic [KEY_W-1:0]    key_d;
    logic                metin_valid_d;
    logic                key_valid_d;
    logic                err_d;
    logic                busy_d;

    // Register value after accepting the current byte; also the source of
    // the published block, so the final byte lands without an extra cycle.
    assign shifted = {shreg_q[KEY_W-9:0], rx_data_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bcnt_d        = bcnt_q;
        tcnt_d        = tcnt_q;
        shreg_d       = shreg_q;
        metin_d       = metin_o;
        key_d         = key_o;
        metin_valid_d = 1'b0;
        key_valid_d   = 1'b0;
        err_d         = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_valid_i) begin
                    if (rx_data_i == HDR_TEXT) begin
                        state_d = RX_TEXT;
                        bcnt_d  = '0;
                        tcnt_d  = '0;
                    end else if (rx_data_i == HDR_KEY) begin
                        state_d = RX_KEY;
                        bcnt_d  = '0;
                        tcnt_d  = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            RX_TEXT, RX_KEY: begin
                if (rx_valid_i) begin
                    // A byte always wins over the timeout threshold.
                    shreg_d = shifted;
                    bcnt_d  = bcnt_q + 6'd1;
                    tcnt_d  = '0;
                    if (state_q == RX_TEXT && bcnt_q == TEXT_LAST) begin
                        metin_d       = shifted[TEXT_W-1:0];
                        metin_valid_d = 1'b1;
                        state_d       = IDLE;
                    end else if (state_q == RX_KEY && bcnt_q == KEY_LAST) begin
                        key_d       = shifted;
                        key_valid_d = 1'b1;
                        state_d     = IDLE;
                    end
                end else if (tcnt_q == TCNT_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    tcnt_d  = '0;
                    bcnt_d  = '0;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bcnt_q        <= '0;
            tcnt_q        <= '0;
            shreg_q       <= '0;
            metin_o       <= '0;
            key_o         <= '0;
            metin_valid_o <= 1'b0;
            key_valid_o   <= 1'b0;
            frame_err_o   <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            bcnt_q        <= bcnt_d;
            tcnt_q        <= tcnt_d;
            shreg_q       <= shreg_d;
            metin_o       <= metin_d;
            key_o         <= key_d;
            metin_valid_o <= metin_valid_d;
            key_valid_o   <= key_valid_d;
            frame_err_o   <= err_d;
            busy_o        <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_frame_assembler.sv
module tb_uart_frame_assembler;

    logic         clk;
    logic         rst_n;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [127:0] metin;
    logic         metin_valid;
    logic [255:0] key;
    logic         key_valid;
    logic         busy;
    logic         frame_err;

    int total = 0;
    int bad   = 0;
    int metin_pulses = 0;
    int key_pulses   = 0;
    int err_pulses   = 0;

    localparam logic [127:0] BLK_A = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [255:0] KEY_1 = 256'h0102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F20;
    localparam logic [127:0] BLK_C = 128'hFEDCBA98765432100F1E2D3C4B5A6978;
    localparam logic [127:0] BLK_D = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] BLK_E = 128'h4D4B4D4B00010203040506074B4D4B4D;
    localparam logic [127:0] BLK_F = 128'h13579BDF02468ACEFDB97531ECA86420;
    localparam logic [127:0] BLK_G = 128'h11111111222222223333333344444444;
    localparam logic [127:0] BLK_H = 128'h55555555666666667777777788888888;
    localparam logic [255:0] KEY_2 = 256'hFFEEDDCCBBAA998877665544332211000123456789ABCDEF0123456789ABCDEF;

    uart_frame_assembler #(
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .rx_data_i     (rx_data),
        .rx_valid_i    (rx_valid),
        .metin_o       (metin),
        .metin_valid_o (metin_valid),
        .key_o         (key),
        .key_valid_o   (key_valid),
        .busy_o        (busy),
        .frame_err_o   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (metin_valid) metin_pulses++;
        if (key_valid)   key_pulses++;
        if (frame_err)   err_pulses++;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Tasks start and end on a falling edge; consecutive calls give
    // a continuous strobe with no idle cycle between bytes.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_block(input logic [255:0] v, input int unsigned first, input int unsigned count);
        for (int unsigned i = first; i < first + count; i++) begin
            send_byte(v[255 - 8*i -: 8]);
        end
    endtask

    task automatic idle(input int unsigned n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_metin", {128'h0, metin}, 256'h0);
        check("reset_key", key, 256'h0);
        check("reset_flags", {252'h0, busy, frame_err, metin_valid, key_valid}, 256'h0);
        rst_n = 1'b1;
        idle(1);

        // Text frame A
        send_byte(8'h4D);
        send_block({BLK_A, 128'h0}, 0, 16);
        check("a_valid", {255'h0, metin_valid}, 256'h1);
        check("a_metin", {128'h0, metin}, {128'h0, BLK_A});
        check("a_key_untouched", key, 256'h0);
        check("a_busy_low", {255'h0, busy}, 256'h0);
        idle(1);
        check("a_valid_one_cycle", {255'h0, metin_valid}, 256'h0);
        check("a_no_err", 256'(err_pulses), 256'd0);

        // Key frame then a text frame that must not alter the key
        send_byte(8'h4B);
        send_block(KEY_1, 0, 32);
        check("k1_valid", {255'h0, key_valid}, 256'h1);
        check("k1_key", key, KEY_1);
        check("k1_metin_kept", {128'h0, metin}, {128'h0, BLK_A});
        idle(1);
        check("k1_valid_one_cycle", {255'h0, key_valid}, 256'h0);
        send_byte(8'h4D);
        send_block({BLK_C, 128'h0}, 0, 16);
        check("c_metin", {128'h0, metin}, {128'h0, BLK_C});
        check("c_key_kept", key, KEY_1);
        idle(1);

        // Timeout after 8 payload bytes
        send_byte(8'h4D);
        send_block({BLK_D, 128'h0}, 0, 8);
        idle(99);
        check("to_busy_before", {255'h0, busy}, 256'h1);
        check("to_err_before", {255'h0, frame_err}, 256'h0);
        idle(1);
        check("to_err", {255'h0, frame_err}, 256'h1);
        check("to_busy_after", {255'h0, busy}, 256'h0);
        check("to_metin_kept", {128'h0, metin}, {128'h0, BLK_C});
        idle(1);
        check("to_err_one_cycle", {255'h0, frame_err}, 256'h0);
        check("to_no_metin_pulse", 256'(metin_pulses), 256'd2);
        send_byte(8'h4D);
        send_block({BLK_D, 128'h0}, 0, 16);
        check("d_metin", {128'h0, metin}, {128'h0, BLK_D});
        idle(1);

        // Unknown header, then payload containing header values
        send_byte(8'h55);
        check("bad_hdr_err", {255'h0, frame_err}, 256'h1);
        check("bad_hdr_idle", {255'h0, busy}, 256'h0);
        idle(1);
        check("bad_hdr_err_one_cycle", {255'h0, frame_err}, 256'h0);
        send_byte(8'h4D);
        send_block({BLK_E, 128'h0}, 0, 16);
        check("e_metin", {128'h0, metin}, {128'h0, BLK_E});
        check("e_valid", {255'h0, metin_valid}, 256'h1);
        idle(1);

        // Byte exactly at the timeout threshold is accepted
        send_byte(8'h4D);
        send_block({BLK_F, 128'h0}, 0, 5);
        idle(99);
        check("thr_busy", {255'h0, busy}, 256'h1);
        send_block({BLK_F, 128'h0}, 5, 11);
        check("thr_no_err", {255'h0, frame_err}, 256'h0);
        check("f_metin", {128'h0, metin}, {128'h0, BLK_F});
        check("f_valid", {255'h0, metin_valid}, 256'h1);

        // Back-to-back frames with no gap
        send_byte(8'h4D);
        send_block({BLK_G, 128'h0}, 0, 16);
        check("g_valid", {255'h0, metin_valid}, 256'h1);
        check("g_metin", {128'h0, metin}, {128'h0, BLK_G});
        send_byte(8'h4D);
        send_block({BLK_H, 128'h0}, 0, 16);
        check("h_valid", {255'h0, metin_valid}, 256'h1);
        check("h_metin", {128'h0, metin}, {128'h0, BLK_H});
        idle(1);
        check("text_pulse_count", 256'(metin_pulses), 256'd7);

        // Asynchronous reset in the middle of a key frame
        send_byte(8'h4B);
        send_block(KEY_2, 0, 10);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_metin", {128'h0, metin}, 256'h0);
        check("rst_key", key, 256'h0);
        check("rst_flags", {252'h0, busy, frame_err, metin_valid, key_valid}, 256'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        send_byte(8'h4B);
        send_block(KEY_2, 0, 32);
        check("k2_valid", {255'h0, key_valid}, 256'h1);
        check("k2_key", key, KEY_2);
        check("k2_metin_zero", {128'h0, metin}, 256'h0);
        idle(2);
        check("key_pulse_count", 256'(key_pulses), 256'd2);
        check("err_pulse_count", 256'(err_pulses), 256'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
